// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider:
// FSM encoding and counter sizing.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_addsub.sv
// Ripple-carry adder/subtractor; op=1 computes a - b.
// Shared by the iteration step and the final remainder correction.
module div_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic [W-1:0] sum
);

  logic [W-1:0] bx;

  assign bx = b ^ {W{op}};

  always_comb begin
    logic cy;
    cy  = op;
    sum = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ bx[i] ^ cy;
      cy     = (a[i] & bx[i]) | (cy & (a[i] ^ bx[i]));
    end
  end

endmodule

// File: rtl/nonrestoring_divider_32.sv
// Sequential non-restoring divider, one quotient bit per cycle,
// signed or unsigned, behind a start/done handshake.
module nonrestoring_divider_32
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  state_t state;

  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   as_a;
  logic [WIDTH:0]   as_b;
  logic [WIDTH:0]   as_sum;
  logic             as_op;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign p_shift = {p[WIDTH-1:0], a[WIDTH-1]};

  // Iterate: subtract while partial remainder is non-negative.
  // Fix: add the divisor back once if it ended negative.
  always_comb begin
    as_a  = p;
    as_op = 1'b0;
    if (state == CALC) begin
      as_a  = p_shift;
      as_op = ~p[WIDTH];
    end
  end

  assign as_b = {1'b0, d};

  div_addsub #(
    .W(WIDTH + 1)
  ) u_addsub (
    .a  (as_a),
    .b  (as_b),
    .op (as_op),
    .sum(as_sum)
  );

  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dividend + ONE) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + ONE) : divisor;

  assign rem_mag = p[WIDTH] ? as_sum[WIDTH-1:0] : p[WIDTH-1:0];
  assign q_fin   = q_neg ? (~a + ONE) : a;
  assign r_fin   = r_neg ? (~rem_mag + ONE) : rem_mag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      p           <= '0;
      a           <= '0;
      d           <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              p     <= '0;
              a     <= dvd_mag;
              d     <= dvs_mag;
              q_neg <= dvd_neg ^ dvs_neg;
              r_neg <= dvd_neg;
              cnt   <= CNT_INIT;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          p   <= as_sum;
          a   <= {a[WIDTH-2:0], ~as_sum[WIDTH]};
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient    <= q_fin;
          remainder   <= r_fin;
          div_by_zero <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider_32.sv
// Randomized self-checking bench for nonrestoring_divider_32
// against a C-semantics arithmetic model with cycle timing.
module tb_nonrestoring_divider_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  nonrestoring_divider_32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_op  (signed_op),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model state
  int          cyc = 0;
  bit          armed = 0;
  bit          pending = 0;
  bit          m_idle = 1;
  int          last_acc = 0;
  int          done_cyc = -100;
  int          completed = 0;
  logic [31:0] e_q, e_r, m_x, m_y;
  logic        e_dz = 1'b0;
  logic [31:0] h_q = '0, h_r = '0;
  logic        h_dz = 1'b0;

  // observed
  int done_seen = 0;
  int last_done_seen = 0;
  int busy_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input logic s, output logic [31:0] q,
                                output logic [31:0] r, output logic dz);
    longint sa, sb;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    dz = 1'b0;
    if (y == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = x;
      dz = 1'b1;
    end else if (s) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Timing model: acceptance only from idle, done 33 edges later
  // (same edge for a zero divisor), idle again the edge after done.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      armed   = 1;
      pending = 0;
      m_idle  = 1;
      h_q     = '0;
      h_r     = '0;
      h_dz    = 1'b0;
    end else begin
      if (m_idle && start) begin
        model(dividend, divisor, signed_op, e_q, e_r, e_dz);
        m_x      = dividend;
        m_y      = divisor;
        pending  = 1;
        m_idle   = 0;
        last_acc = cyc;
        done_cyc = cyc + (e_dz ? 0 : 33);
        if (e_dz) begin
          h_q  = e_q;
          h_r  = e_r;
          h_dz = 1'b1;
        end
      end else if (pending && cyc == done_cyc) begin
        h_q  = e_q;
        h_r  = e_r;
        h_dz = 1'b0;
      end
      if (pending && cyc == done_cyc + 1) begin
        pending = 0;
        m_idle  = 1;
        completed++;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      logic exp_busy, exp_done;
      exp_busy = pending && !e_dz && cyc >= last_acc && cyc < done_cyc;
      exp_done = pending && cyc == done_cyc;
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("quotient", quotient, h_q);
      chk("remainder", remainder, h_r);
      chk("div_by_zero", 32'(div_by_zero), 32'(h_dz));
      if (done) begin
        done_seen++;
        last_done_seen = cyc;
      end
      if (busy) busy_total++;
      if (exp_done && !e_dz)
        chk("invariant", quotient * m_y + remainder, m_x);
    end
  end

  task automatic wait_idle();
    int guard = 0;
    while (!m_idle && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!m_idle) begin
      fails++;
      $display("FAIL wait_idle: timeout at cycle %0d", cyc);
    end
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input logic s);
    wait_idle();
    dividend  = x;
    divisor   = y;
    signed_op = s;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic dir(input string nm, input logic [31:0] x,
                     input logic [31:0] y, input logic s,
                     input logic [31:0] q, input logic [31:0] r,
                     input logic dz, input int lat);
    int b0;
    b0 = busy_total;
    do_op(x, y, s);
    wait_idle();
    chk({nm, " q"}, quotient, q);
    chk({nm, " r"}, remainder, r);
    chk({nm, " dz"}, 32'(div_by_zero), 32'(dz));
    chk({nm, " latency"}, 32'(last_done_seen - last_acc + 1), 32'(lat));
    chk({nm, " busy cycles"}, 32'(busy_total - b0), dz ? 32'd0 : 32'd33);
  endtask

  initial begin
    logic [31:0] x, y;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset q", quotient, 32'd0);
    chk("reset r", remainder, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);

    dir("u 100/7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34);
    dir("s -100/7", -32'sd100, 32'd7, 1'b1,
        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    dir("s 100/-7", 32'd100, -32'sd7, 1'b1,
        32'hFFFF_FFF2, 32'd2, 1'b0, 34);
    dir("u div0", 32'h1234_5678, 32'd0, 1'b0,
        32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1);
    dir("s div0", 32'h1234_5678, 32'd0, 1'b1,
        32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1);
    dir("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
        32'h8000_0000, 32'd0, 1'b0, 34);
    dir("u ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
        32'd0, 32'h8000_0000, 1'b0, 34);

    // start during busy is ignored
    do_op(32'd1000, 32'd3, 1'b0);
    repeat (9) @(negedge clk);
    dividend = 32'd77;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("ignored start q", quotient, 32'd333);
    chk("ignored start r", remainder, 32'd1);

    // reset mid-operation aborts
    do_op(32'd5000, 32'd7, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort q", quotient, 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    dir("after abort", 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 34);

    for (int i = 0; i < 2000; i++) begin
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 15));
        2: y = 32'hFFFF_FFFF;
        3: x = 32'h8000_0000;
        4: y = y >> $urandom_range(1, 31);
        5: y = 32'h8000_0000;
        default: ;
      endcase
      do_op(x, y, 1'($urandom_range(0, 1)));
    end
    wait_idle();
    chk("done count", 32'(done_seen), 32'(completed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
